// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register: payload + valid, with stall/bubble/flush handling and hold-age tracking.
// Optional bubble/flush performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int                 DATA_W   = 128,
    parameter int                 STALL_W  = 6,
    parameter int                 STAGE    = 3,
    parameter logic [DATA_W-1:0]  NOP_DATA = {DATA_W{1'b0}},
    parameter int                 AGE_W    = 4,
    parameter int                 CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_fresh,
    output logic [AGE_W-1:0]    hold_age,
    output logic [CNT_W-1:0]    bubble_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_FLUSH
    } act_e;

    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    logic up;
    logic dn;
    act_e act;

    assign up = stall[STAGE];
    assign dn = stall[STAGE+1];

    // Only the producer and consumer stall bits matter; the rest of the bus is shared with other boundaries.
    logic unused_stall;
    assign unused_stall = ^stall;

    // NOTE: act gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        act = ACT_ADVANCE;
        if (flush)
            act = ACT_FLUSH;
        else if (up && !dn)
            act = ACT_BUBBLE;
        else if (up && dn)
            act = ACT_HOLD;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= NOP_DATA;
            out_fresh <= 1'b0;
            hold_age  <= '0;
        end else begin
            unique case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    out_valid <= 1'b0;
                    out_data  <= NOP_DATA;
                    out_fresh <= 1'b0;
                    hold_age  <= '0;
                end
                ACT_HOLD: begin
                    out_fresh <= 1'b0;
                    if (!out_valid)
                        hold_age <= '0;
                    else if (hold_age != AGE_MAX)
                        hold_age <= hold_age + 1'b1;
                end
                default: begin
                    out_valid <= in_valid;
                    out_data  <= in_valid ? in_data : NOP_DATA;
                    out_fresh <= in_valid;
                    hold_age  <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (act == ACT_BUBBLE && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + 1'b1;
            // Only real instructions count as killed; flushing an empty slot is free.
            if (act == ACT_FLUSH && out_valid && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

    // Consumer stalled while producer runs would overwrite an entry the consumer still needs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(dn && !up))
            else $warning("pipe_stage_reg STAGE=%0d: illegal stall combination (consumer stalled, producer running)", STAGE);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard testbench for pipe_stage_reg: a reference model queues expected outputs per edge, popped after each edge.
module tb_pipe_stage_reg;

    localparam int               DATA_W  = 128;
    localparam int               STALL_W = 6;
    localparam int               STAGE   = 3;
    localparam int               AGE_W   = 4;
    localparam int               CNT_W   = 16;
    localparam logic [DATA_W-1:0] NOP    = '0;

    localparam logic [STALL_W-1:0] ST_RUN     = 6'b000000;
    localparam logic [STALL_W-1:0] ST_BUBBLE  = 6'b001000;
    localparam logic [STALL_W-1:0] ST_HOLD    = 6'b011000;
    localparam logic [STALL_W-1:0] ST_ILLEGAL = 6'b010000;
    localparam logic [STALL_W-1:0] ST_OTHERS  = 6'b100111;

    typedef struct packed {
        logic                valid;
        logic [DATA_W-1:0]   data;
        logic                fresh;
        logic [AGE_W-1:0]    age;
        logic [CNT_W-1:0]    bub;
        logic [CNT_W-1:0]    fl;
    } obs_t;

    typedef struct packed {
        logic                rst;
        logic                flush;
        logic [STALL_W-1:0]  stall;
        logic                iv;
        logic [DATA_W-1:0]   id;
    } st_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [STALL_W-1:0]  stall;
    logic                flush;
    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                out_fresh;
    logic [AGE_W-1:0]    hold_age;
    logic [CNT_W-1:0]    bubble_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    int checks   = 0;
    int failures = 0;

    obs_t m;
    obs_t sb[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W  (DATA_W),
        .STALL_W (STALL_W),
        .STAGE   (STAGE),
        .NOP_DATA(NOP),
        .AGE_W   (AGE_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_fresh (out_fresh),
        .hold_age  (hold_age),
        .bubble_cnt(bubble_cnt),
        .flush_cnt (flush_cnt)
    );

    function automatic st_t mk(logic r, logic f, logic [STALL_W-1:0] s, logic v, logic [DATA_W-1:0] d);
        st_t t;
        t.rst = r; t.flush = f; t.stall = s; t.iv = v; t.id = d;
        return t;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.valid = out_valid; o.data = out_data; o.fresh = out_fresh;
        o.age = hold_age; o.bub = bubble_cnt; o.fl = flush_cnt;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("valid=%b data=%h fresh=%b age=%0d bub=%0d fl=%0d",
                         o.valid, o.data, o.fresh, o.age, o.bub, o.fl);
    endfunction

    // Drive one edge's inputs at the falling edge and queue what the outputs must be after the next rising edge.
    task automatic apply(st_t s);
        logic up, dn;
        @(negedge clk);
        rst = s.rst; flush = s.flush; stall = s.stall; in_valid = s.iv; in_data = s.id;
        up = s.stall[STAGE];
        dn = s.stall[STAGE+1];
        if (s.rst) begin
            m = '0;
            m.data = NOP;
        end else if (s.flush) begin
`ifdef PIPE_STAGE_PERF_EN
            if (m.valid && m.fl != '1) m.fl = m.fl + 1;
`endif
            m.valid = 1'b0; m.data = NOP; m.fresh = 1'b0; m.age = '0;
        end else if (up && !dn) begin
`ifdef PIPE_STAGE_PERF_EN
            if (m.bub != '1) m.bub = m.bub + 1;
`endif
            m.valid = 1'b0; m.data = NOP; m.fresh = 1'b0; m.age = '0;
        end else if (up && dn) begin
            m.fresh = 1'b0;
            if (!m.valid) m.age = '0;
            else if (m.age != '1) m.age = m.age + 1;
        end else begin
            m.valid = s.iv;
            m.data  = s.iv ? s.id : NOP;
            m.fresh = s.iv;
            m.age   = '0;
        end
        sb.push_back(m);
    endtask

    task automatic test_reset();
        st_t q[$];
        obs_t got, exp;
        q.push_back(mk(1, 1, ST_HOLD, 1, 128'hFFFF));
        q.push_back(mk(1, 0, ST_RUN,  1, 128'h1111));
        foreach (q[i]) begin
            apply(q[i]);
            @(posedge clk); #1;
            checks++;
            if (sb.size() == 0) begin
                failures++; $display("FAIL reset[%0d]: no expectation queued", i);
            end else begin
                exp = sb.pop_front(); got = observe();
                if (got !== exp) begin
                    failures++; $display("FAIL reset[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
                end
            end
        end
    endtask

    task automatic test_advance();
        st_t q[$];
        obs_t got, exp;
        q.push_back(mk(0, 0, ST_RUN,  1, 128'h1234));
        q.push_back(mk(0, 0, ST_HOLD, 1, 128'h9999));
        q.push_back(mk(0, 0, ST_RUN,  1, 128'h4321));
        q.push_back(mk(0, 0, ST_RUN,  1, 128'h5678));
        foreach (q[i]) begin
            apply(q[i]);
            @(posedge clk); #1;
            checks++;
            if (sb.size() == 0) begin
                failures++; $display("FAIL advance[%0d]: no expectation queued", i);
            end else begin
                exp = sb.pop_front(); got = observe();
                if (got !== exp) begin
                    failures++; $display("FAIL advance[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
                end
            end
        end
    endtask

    task automatic test_bubble();
        st_t q[$];
        obs_t got, exp;
        q.push_back(mk(0, 0, ST_BUBBLE, 1, 128'hABCD));
        q.push_back(mk(0, 0, ST_RUN,    1, 128'hABCD));
        q.push_back(mk(0, 0, ST_BUBBLE, 1, 128'hABCE));
        foreach (q[i]) begin
            apply(q[i]);
            @(posedge clk); #1;
            checks++;
            if (sb.size() == 0) begin
                failures++; $display("FAIL bubble[%0d]: no expectation queued", i);
            end else begin
                exp = sb.pop_front(); got = observe();
                if (got !== exp) begin
                    failures++; $display("FAIL bubble[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
                end
            end
        end
    endtask

    task automatic test_hold_age();
        st_t q[$];
        obs_t got, exp;
        q.push_back(mk(0, 0, ST_RUN, 1, 128'h55));
        for (int k = 0; k < 20; k++) q.push_back(mk(0, 0, ST_HOLD, 1, 128'h66 + k));
        q.push_back(mk(0, 0, ST_RUN, 0, 128'h0));
        foreach (q[i]) begin
            apply(q[i]);
            @(posedge clk); #1;
            checks++;
            if (sb.size() == 0) begin
                failures++; $display("FAIL hold_age[%0d]: no expectation queued", i);
            end else begin
                exp = sb.pop_front(); got = observe();
                if (got !== exp) begin
                    failures++; $display("FAIL hold_age[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
                end
            end
        end
    endtask

    task automatic test_flush();
        st_t q[$];
        obs_t got, exp;
        q.push_back(mk(0, 0, ST_RUN,  1, 128'h77));
        for (int k = 0; k < 3; k++) q.push_back(mk(0, 0, ST_HOLD, 1, 128'h88));
        q.push_back(mk(0, 1, ST_HOLD, 1, 128'h88));
        q.push_back(mk(0, 1, ST_HOLD, 1, 128'h88));
        q.push_back(mk(0, 1, ST_RUN,  1, 128'h99));
        foreach (q[i]) begin
            apply(q[i]);
            @(posedge clk); #1;
            checks++;
            if (sb.size() == 0) begin
                failures++; $display("FAIL flush[%0d]: no expectation queued", i);
            end else begin
                exp = sb.pop_front(); got = observe();
                if (got !== exp) begin
                    failures++; $display("FAIL flush[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
                end
            end
        end
    endtask

    task automatic test_invalid();
        st_t q[$];
        obs_t got, exp;
        q.push_back(mk(0, 0, ST_RUN, 1, 128'h3333));
        q.push_back(mk(0, 0, ST_RUN, 0, 128'hDEAD));
        foreach (q[i]) begin
            apply(q[i]);
            @(posedge clk); #1;
            checks++;
            if (sb.size() == 0) begin
                failures++; $display("FAIL invalid[%0d]: no expectation queued", i);
            end else begin
                exp = sb.pop_front(); got = observe();
                if (got !== exp) begin
                    failures++; $display("FAIL invalid[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
                end
            end
        end
    endtask

    task automatic test_priority();
        st_t q[$];
        obs_t got, exp;
        q.push_back(mk(0, 0, ST_BUBBLE,  0, 128'h0));
        q.push_back(mk(0, 0, ST_RUN,     1, 128'hAA));
        q.push_back(mk(0, 0, ST_HOLD,    1, 128'hBB));
        q.push_back(mk(0, 0, ST_HOLD,    1, 128'hBB));
        q.push_back(mk(1, 1, ST_HOLD,    1, 128'hCC));
        q.push_back(mk(0, 0, ST_ILLEGAL, 1, 128'h99));
        q.push_back(mk(0, 0, ST_OTHERS,  1, 128'hBEEF));
        foreach (q[i]) begin
            apply(q[i]);
            @(posedge clk); #1;
            checks++;
            if (sb.size() == 0) begin
                failures++; $display("FAIL priority[%0d]: no expectation queued", i);
            end else begin
                exp = sb.pop_front(); got = observe();
                if (got !== exp) begin
                    failures++; $display("FAIL priority[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        st_t s;
        obs_t got, exp;
        for (int i = 0; i < 80; i++) begin
            s.rst   = 1'b0;
            s.flush = ($urandom_range(0, 7) == 0);
            s.stall = STALL_W'($urandom);
            if (!s.stall[STAGE]) s.stall[STAGE+1] = 1'b0;
            s.iv    = $urandom_range(0, 1) == 1;
            s.id    = {$urandom, $urandom, $urandom, $urandom};
            apply(s);
            @(posedge clk); #1;
            checks++;
            if (sb.size() == 0) begin
                failures++; $display("FAIL back_to_back[%0d]: no expectation queued", i);
            end else begin
                exp = sb.pop_front(); got = observe();
                if (got !== exp) begin
                    failures++; $display("FAIL back_to_back[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = '0; in_valid = 1'b0; in_data = '0;
        m = '0;
        test_reset();
        test_advance();
        test_bubble();
        test_hold_age();
        test_flush();
        test_invalid();
        test_priority();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
